// File: rtl/counter_monitor_if.sv
// Observation bus between a free-running counter and its sequence monitor.
// master drives the sampled count and clear; slave returns lock status and statistics.
interface counter_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int STAT_W = 8
);
  logic              cnt_valid;
  logic [WIDTH-1:0]  cnt_in;
  logic              clr;
  logic              locked;
  logic              err;
  logic              restart;
  logic [STAT_W-1:0] err_count;
  logic [STAT_W-1:0] wrap_count;

  modport master (
    output cnt_valid, cnt_in, clr,
    input  locked, err, restart, err_count, wrap_count
  );

  modport slave (
    input  cnt_valid, cnt_in, clr,
    output locked, err, restart, err_count, wrap_count
  );
endinterface

// File: rtl/counter_monitor.sv
// In-design sequence checker for a free-running binary counter: learns the count,
// locks on, then reports increment violations, restarts and wrap-arounds.
//
// state  | meaning
// IDLE   | nothing sampled since reset
// ACQ    | last holds a sample; counting consecutive correct increments in match
// LOCKED | tracking; any break ends the lock with err or restart
module counter_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 3,
  parameter int STAT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  counter_monitor_if.slave mon
);
  localparam int MW = (LOCK_LEN < 1) ? 1 : $clog2(LOCK_LEN + 1);
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  last, last_n;
  logic [MW-1:0]     match, match_n;
  logic              locked_q, err_q, restart_q;
  logic              err_n, restart_n;
  logic              err_inc, wrap_inc;
  logic [STAT_W-1:0] err_count_q, wrap_count_q;

  logic [WIDTH-1:0]  next_val;
  logic [MW-1:0]     match_inc;

  assign next_val  = last + WIDTH'(1);
  assign match_inc = match + MW'(1);

  always_comb begin
    state_n   = state;
    last_n    = last;
    match_n   = match;
    err_n     = 1'b0;
    restart_n = 1'b0;
    err_inc   = 1'b0;
    wrap_inc  = 1'b0;
    if (mon.cnt_valid) begin
      last_n = mon.cnt_in;
      unique case (state)
        IDLE: begin
          match_n = '0;
          state_n = ACQ;
        end
        ACQ: begin
          if (mon.cnt_in == next_val) begin
            match_n = match_inc;
            if (match_inc == MW'(LOCK_LEN))
              state_n = LOCKED;
          end else begin
            // s != next here, so a zero is always an unexpected restart
            match_n   = '0;
            restart_n = (mon.cnt_in == '0);
          end
        end
        LOCKED: begin
          if (mon.cnt_in == next_val) begin
            wrap_inc = (last == MAX);
          end else if (mon.cnt_in == '0) begin
            restart_n = 1'b1;
            match_n   = '0;
            state_n   = ACQ;
          end else begin
            err_n   = 1'b1;
            err_inc = 1'b1;
            match_n = '0;
            state_n = ACQ;
          end
        end
        default: begin
          match_n = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= '0;
      match     <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      match     <= match_n;
      locked_q  <= (state_n == LOCKED);
      err_q     <= err_n;
      restart_q <= restart_n;
    end
  end

  // Statistics saturate at all-ones; clr takes priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else if (mon.clr) begin
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      if (err_inc && !(&err_count_q))
        err_count_q <= err_count_q + STAT_W'(1);
      if (wrap_inc && !(&wrap_count_q))
        wrap_count_q <= wrap_count_q + STAT_W'(1);
    end
  end

  assign mon.locked     = locked_q;
  assign mon.err        = err_q;
  assign mon.restart    = restart_q;
  assign mon.err_count  = err_count_q;
  assign mon.wrap_count = wrap_count_q;
endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: directed scenarios plus random traffic, two instances
// (8-bit and 2-bit statistics) compared against a sample-level reference model.
module tb_counter_monitor;
  localparam int WIDTH    = 4;
  localparam int LOCK_LEN = 3;
  localparam int MODV     = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_monitor_if #(.WIDTH(WIDTH), .STAT_W(8)) bus0 ();
  counter_monitor_if #(.WIDTH(WIDTH), .STAT_W(2)) bus1 ();

  counter_monitor #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .STAT_W(8)) dut0 (
    .clk(clk), .rst(rst), .mon(bus0.slave));
  counter_monitor #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .STAT_W(2)) dut1 (
    .clk(clk), .rst(rst), .mon(bus1.slave));

  int checks = 0;
  int passed = 0;

  // Reference model, one slot per instance; sat is the statistic ceiling.
  bit m_have  [2];
  int m_last  [2];
  int m_run   [2];
  bit m_lock  [2];
  bit m_err   [2];
  bit m_rst   [2];
  int m_errs  [2];
  int m_wraps [2];
  int sat     [2] = '{255, 3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_have[d] = 0; m_last[d] = 0; m_run[d] = 0; m_lock[d] = 0;
      m_err[d] = 0; m_rst[d] = 0; m_errs[d] = 0; m_wraps[d] = 0;
    end
  endtask

  // One clock edge of the spec's behaviour, expressed per sample.
  task automatic model_edge(input bit v, input int s, input bit c);
    for (int d = 0; d < 2; d++) begin
      bit correct;
      m_err[d] = 0;
      m_rst[d] = 0;
      if (v) begin
        if (!m_have[d]) begin
          m_have[d] = 1;
          m_run[d]  = 0;
        end else begin
          correct = (s == (m_last[d] + 1) % MODV);
          if (m_lock[d]) begin
            if (correct) begin
              if (m_last[d] == MODV - 1 && m_wraps[d] < sat[d]) m_wraps[d]++;
            end else begin
              m_lock[d] = 0;
              m_run[d]  = 0;
              if (s == 0) m_rst[d] = 1;
              else begin
                m_err[d] = 1;
                if (m_errs[d] < sat[d]) m_errs[d]++;
              end
            end
          end else if (correct) begin
            m_run[d]++;
            if (m_run[d] == LOCK_LEN) m_lock[d] = 1;
          end else begin
            m_run[d] = 0;
            if (s == 0) m_rst[d] = 1;
          end
        end
        m_last[d] = s;
      end
      if (c) begin
        m_errs[d]  = 0;
        m_wraps[d] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".locked0"},  bus0.locked,     m_lock[0]);
    check({tag, ".err0"},     bus0.err,        m_err[0]);
    check({tag, ".restart0"}, bus0.restart,    m_rst[0]);
    check({tag, ".errc0"},    bus0.err_count,  m_errs[0]);
    check({tag, ".wrapc0"},   bus0.wrap_count, m_wraps[0]);
    check({tag, ".locked1"},  bus1.locked,     m_lock[1]);
    check({tag, ".err1"},     bus1.err,        m_err[1]);
    check({tag, ".restart1"}, bus1.restart,    m_rst[1]);
    check({tag, ".errc1"},    bus1.err_count,  m_errs[1]);
    check({tag, ".wrapc1"},   bus1.wrap_count, m_wraps[1]);
  endtask

  task automatic step(input bit v, input int s, input bit c, input string tag);
    @(negedge clk);
    bus0.cnt_valid = v; bus0.cnt_in = WIDTH'(s); bus0.clr = c;
    bus1.cnt_valid = v; bus1.cnt_in = WIDTH'(s); bus1.clr = c;
    @(posedge clk);
    model_edge(v, s, c);
    #1;
    check_all(tag);
  endtask

  task automatic relock_then_violate(input string tag);
    int b;
    b = m_last[0];
    for (int i = 1; i <= LOCK_LEN; i++) step(1, (b + i) % MODV, 0, tag);
    check({tag, ".is_locked"}, bus0.locked, 1);
    step(1, (b + LOCK_LEN + 2) % MODV, 0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.cnt_valid = 0; bus0.cnt_in = '0; bus0.clr = 0;
    bus1.cnt_valid = 0; bus1.cnt_in = '0; bus1.clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst = 1'b0;

    // Count through a full wrap, locking after sample 3
    for (int i = 0; i < 16; i++) step(1, i, 0, "seq");
    for (int i = 0; i < 9; i++) step(1, i, 0, "seq_wrap");
    check("wrap_seen", bus0.wrap_count, 1);

    // Skip a value: err, then relock on 11..14
    step(1, 10, 0, "skip");
    check("skip_err", bus0.err, 1);
    for (int i = 11; i <= 14; i++) step(1, i, 0, "relock");
    check("relock_lock", bus0.locked, 1);

    // Counter restart from 9
    step(1, 15, 0, "pre"); for (int i = 0; i <= 9; i++) step(1, i, 0, "pre");
    step(1, 0, 0, "restart");
    check("restart_pulse", bus0.restart, 1);
    for (int i = 1; i <= 4; i++) step(1, i, 0, "relock2");

    // Valid gap with garbage on the bus
    step(1, 5, 0, "gap");
    for (int i = 0; i < 5; i++) step(0, $urandom_range(0, MODV - 1), 0, "gap_idle");
    step(1, 6, 0, "gap_end");
    check("gap_locked", bus0.locked, 1);

    // Five violations saturate the 2-bit counter; then clr against a violation
    for (int k = 0; k < 5; k++) relock_then_violate("sat");
    check("sat_errc1", bus1.err_count, 3);
    begin
      int b;
      b = m_last[0];
      for (int i = 1; i <= LOCK_LEN; i++) step(1, (b + i) % MODV, 0, "clr_pre");
      step(1, (b + LOCK_LEN + 2) % MODV, 1, "clr_viol");
      check("clr_err_pulse", bus0.err, 1);
      check("clr_errc", bus0.err_count, 0);
    end

    // Async reset mid-cycle while locked with err_count=2
    relock_then_violate("ar");
    relock_then_violate("ar");
    begin
      int b;
      b = m_last[0];
      for (int i = 1; i <= LOCK_LEN; i++) step(1, (b + i) % MODV, 0, "ar_lock");
    end
    check("ar_pre_errc", bus0.err_count, 2);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk) rst = 1'b0;
    step(1, 7, 0, "seed");
    for (int i = 8; i <= 10; i++) step(1, i, 0, "post_rst");
    check("post_rst_lock", bus0.locked, 1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int r, s;
      r = $urandom_range(0, 9);
      if (r < 7)       s = (m_last[0] + 1) % MODV;
      else if (r == 7) s = 0;
      else if (r == 8) s = $urandom_range(0, MODV - 1);
      else             s = m_last[0];
      step($urandom_range(0, 9) < 8, s, $urandom_range(0, 29) == 0, "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
